// File: rtl/letter_ram_writer.sv
// Write-side engine for the 1-bit letter bitmap RAM: draws font glyphs pixel by pixel
// or fills the whole bitmap with CLEAR_VAL, one RAM write per clock.
module letter_ram_writer #(
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 8,
  parameter int unsigned GLYPH_H   = 16,
  parameter logic        CLEAR_VAL = 1'b0,
  localparam int unsigned ROW_W    = $clog2(GLYPH_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_clear,
  input  logic [7:0]         cmd_char,
  input  logic [X_W-1:0]     cmd_x,
  input  logic [Y_W-1:0]     cmd_y,
  output logic [6+ROW_W:0]   font_addr,
  input  logic [7:0]         font_data,
  output logic [15:0]        ada,
  output logic               din,
  output logic               cea,
  output logic               busy
);

  typedef enum logic [2:0] {StIdle, StClear, StFetch, StLatch, StWrite} state_e;

  state_e             state_q, state_d;
  logic [7:0]         char_q, char_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [7:0]         sh_q, sh_d;
  logic [15:0]        ada_q, ada_d;
  logic               din_q, din_d;
  logic               cea_q, cea_d;
  logic [6+ROW_W:0]   fa_q, fa_d;

  logic [2:0]         pix_col;
  logic               pix_bit;
  logic [X_W:0]       px;
  logic [Y_W:0]       py;
  logic               clip;
  logic               emit;
  logic [ROW_W-1:0]   row_inc;

  // Pixel computed here is the one presented in the cycle after the current edge.
  always_comb begin
    pix_col = (state_q == StWrite) ? col_q + 3'd1 : 3'd0;
    pix_bit = (state_q == StWrite) ? sh_q[7] : font_data[7];
    px      = {1'b0, x_q} + (X_W + 1)'(pix_col);
    py      = {1'b0, y_q} + (Y_W + 1)'(row_q);
    clip    = px[X_W] | py[Y_W];
    row_inc = row_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    col_d   = col_q;
    sh_d    = sh_q;
    ada_d   = ada_q;
    fa_d    = fa_q;
    din_d   = 1'b0;
    cea_d   = 1'b0;
    emit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          char_d = cmd_char;
          x_d    = cmd_x;
          y_d    = cmd_y;
          row_d  = '0;
          col_d  = '0;
          if (cmd_clear) begin
            state_d = StClear;
            ada_d   = '0;
            cea_d   = 1'b1;
            din_d   = CLEAR_VAL;
          end else begin
            state_d = StFetch;
            fa_d    = {cmd_char[6:0], {ROW_W{1'b0}}};
          end
        end
      end
      StClear: begin
        if (ada_q == 16'hFFFF) begin
          state_d = StIdle;
        end else begin
          ada_d = ada_q + 16'd1;
          cea_d = 1'b1;
          din_d = CLEAR_VAL;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        state_d = StWrite;
        col_d   = 3'd0;
        sh_d    = {font_data[6:0], 1'b0};
        emit    = 1'b1;
      end
      StWrite: begin
        if (col_q == 3'd7) begin
          if (row_q == ROW_W'(GLYPH_H - 1)) begin
            state_d = StIdle;
          end else begin
            row_d   = row_inc;
            fa_d    = {char_q[6:0], row_inc};
            state_d = StFetch;
          end
        end else begin
          col_d = col_q + 3'd1;
          sh_d  = {sh_q[6:0], 1'b0};
          emit  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Clipped pixels keep their slot and wrapped address but never write.
    if (emit) begin
      ada_d = {py[Y_W-1:0], px[X_W-1:0]};
      cea_d = ~clip;
      din_d = ~clip & (pix_bit ^ char_q[7]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      char_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sh_q    <= '0;
      ada_q   <= '0;
      din_q   <= 1'b0;
      cea_q   <= 1'b0;
      fa_q    <= '0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      x_q     <= x_d;
      y_q     <= y_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sh_q    <= sh_d;
      ada_q   <= ada_d;
      din_q   <= din_d;
      cea_q   <= cea_d;
      fa_q    <= fa_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign font_addr = fa_q;
  assign ada       = ada_q;
  assign din       = din_q;
  assign cea       = cea_q;

endmodule

// File: doc/letter_ram_writer.md
Name: letter_ram_writer

Overview:
- Write-side engine for the 1-bit letter display RAM (64K x 1, port A: ada/din/cea).
- Accepts character-draw and clear commands over a valid/ready handshake.
- Fetches 8-pixel glyph rows from an external font ROM and writes one pixel per clock into the bitmap.
- The display scanner reads the same RAM on port B.

Parameters:
- X_W, 8, bitmap x width in bits (2^X_W pixels per line).
- Y_W, 8, bitmap y width in bits. X_W+Y_W must equal 16 (RAM address width).
- GLYPH_H, 16, glyph rows. Power of two; ROW_W = log2(GLYPH_H).
- CLEAR_VAL, 1'b0, pixel value written by a clear command.

Ports:
- clk  in  1  single clock; also drives the RAM clka.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_clear  in  1  1 = fill whole bitmap with CLEAR_VAL. Takes priority over char.
- cmd_char  in  8  [6:0] = glyph code; [7] = inverse video.
- cmd_x  in  X_W  top-left pixel x.
- cmd_y  in  Y_W  top-left pixel y.
- font_addr  out  7+ROW_W  {char[6:0], row}. ROM returns font_data 1 cycle later.
- font_data  in  8  glyph row; bit7 = leftmost pixel.
- ada  out  16  RAM write address = {y, x}.
- din  out  1  RAM write data.
- cea  out  1  RAM write enable, one pixel per high cycle.
- busy  out  1  equals ~cmd_ready.

Behaviour:
- Reset values: state=IDLE, ada=0, din=0, cea=0, font_addr=0, all counters 0.
- Reset is sampled at the clock edge. Asserting it mid-operation aborts:
  - cea is low from the next cycle.
  - Already-written pixels stay in the RAM.
- Handshake:
  - A command is accepted on the edge where cmd_valid && cmd_ready.
  - Command fields are latched on that edge.
  - cmd_valid is ignored while busy.
- FSM: IDLE, CLEAR, FETCH, LATCH, WRITE.
  - IDLE -> CLEAR if cmd_clear, else -> FETCH (row=0).
  - FETCH: font_addr = {char[6:0], row}; 1 cycle.
  - LATCH: capture font_data into an 8-bit shift register; 1 cycle.
  - WRITE: 8 cycles, col 0..7, shift MSB-first.
  - After col 7: row<GLYPH_H-1 -> FETCH with row+1; else -> IDLE.
- Glyph timing (acceptance edge = end of cycle 0):
  - Row r occupies cycles 10r+1 .. 10r+10.
  - cea is high in cycles 10r+3 .. 10r+10, one per column.
  - The last write is in cycle 10*GLYPH_H (160 by default).
  - cmd_ready is high in cycle 10*GLYPH_H+1.
- WRITE datapath:
  - ada = {(y+r)[Y_W-1:0], (x+c)[X_W-1:0]}.
  - din = glyph_bit XOR char[7].
- Clipping: x+c and y+r are computed with one extra bit.
  - If either overflows, cea=0 and din=0 for that cycle, and ada holds the wrapped value.
  - Cycle count is unchanged: clipped pixels still consume their slot.
- CLEAR:
  - Cycles 1 .. 2^16 after acceptance: cea=1, din=CLEAR_VAL, ada counts 0 .. 0xFFFF.
  - The address counter terminates on 0xFFFF with no wrap.
  - IDLE follows, and cmd_ready is high in cycle 2^16+1.
- Font codes: char[6:0] is passed through unchanged. The block does no code validation (the ROM owns code mapping).
- font_addr holds its last value outside FETCH.
- Back-to-back commands: a new command can be accepted in the first IDLE cycle. There is no extra idle gap.

Test Plan:
- Reset, then char 0x41 at (10,20) with the ROM model returning 0x18 for row 0:
  - cycle 1: font_addr=0x410.
  - cycles 3..10: cea=1, ada=0x140A..0x1411, din=0,0,0,1,1,0,0,0.
  - cmd_ready=1 at cycle 161.
- Char 0xC1 at (10,20): font_addr still 0x410; row 0 din=1,1,1,0,0,1,1,1.
- Char 0x41 at (252,250):
  - rows 0..5: cea high only for cols 0..3.
  - rows 6..15: cea never high.
  - cmd_ready=1 at cycle 161 (same as unclipped).
- cmd_clear=1 with cmd_char=0x41 present:
  - 65536 consecutive cea cycles, first ada=0x0000, last ada=0xFFFF, din=CLEAR_VAL.
  - font_addr never enters FETCH.
  - cmd_ready=1 at cycle 65537.
- reset pulsed at cycle 50 of a glyph:
  - cycle after reset: cea=0, cmd_ready=1.
  - A new char command is then accepted and follows the exact nominal timing.
- cmd_valid held high across two char commands:
  - second accepted on the edge ending cycle 161.
  - its first cea occurs at cycle 164.
  - cmd_ready is low throughout the first glyph.
